// File: rtl/i2c_passthru_idle_stuck_recover_mc.sv
`default_nettype none
// ============================================================================
// Module   : i2c_passthru_idle_stuck_recover_mc
// Purpose  : Multi-channel I2C/SMBus bus monitor and recoverer. Each channel
//            tracks bus idle (STOP qualified, or SCL&SDA high timeout) and
//            stuck-bus (no edge while not both high). A single shared
//            recovery sequencer is granted round-robin and issues START,
//            up to RECOV_CLKS SCL pulses, then STOP. A per-channel attempt
//            limit raises a sticky fail flag.
// Ports    : i_clk, i_rst (sync, active high), i_f_ref / i_f_ref_slow
//            (timing references, rising edge = tick), i_sda / i_scl (sampled
//            bus lines, bit n = channel n), i_clr_fail (clear fail+attempts),
//            o_sda / o_scl (1 = release, 0 = pull low), o_idle,
//            o_idle_timeout (1-cycle), o_stuck, o_fail, o_recov_busy,
//            o_recov_ch (granted channel, valid while busy).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_passthru_idle_stuck_recover_mc #(
    parameter int NUM_CH                 = 2,
    parameter int F_REF_T_LOW            = 38,
    parameter int F_REF_T_HI             = 400,
    parameter int F_REF_SLOW_T_STUCK_MAX = 255,
    parameter int RECOV_CLKS             = 9,
    parameter int MAX_ATTEMPTS           = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_f_ref,
    input  logic              i_f_ref_slow,
    input  logic [NUM_CH-1:0] i_sda,
    input  logic [NUM_CH-1:0] i_scl,
    input  logic [NUM_CH-1:0] i_clr_fail,
    output logic [NUM_CH-1:0] o_sda,
    output logic [NUM_CH-1:0] o_scl,
    output logic [NUM_CH-1:0] o_idle,
    output logic [NUM_CH-1:0] o_idle_timeout,
    output logic [NUM_CH-1:0] o_stuck,
    output logic [NUM_CH-1:0] o_fail,
    output logic              o_recov_busy,
    output logic [2:0]        o_recov_ch
);

    localparam int WIDTH_T_LOW = $clog2(F_REF_T_LOW + 1);
    localparam int WIDTH_T_HI  = $clog2(F_REF_T_HI + 1);
    localparam int WIDTH_STUCK = $clog2(F_REF_SLOW_T_STUCK_MAX + 1);

    localparam logic [WIDTH_T_LOW-1:0] c_t_low  = WIDTH_T_LOW'(F_REF_T_LOW);
    localparam logic [WIDTH_T_HI-1:0]  c_t_hi   = WIDTH_T_HI'(F_REF_T_HI);
    localparam logic [WIDTH_STUCK-1:0] c_t_stk  = WIDTH_STUCK'(F_REF_SLOW_T_STUCK_MAX);
    localparam logic [3:0]             c_pulses = 4'(RECOV_CLKS);
    localparam logic [2:0]             c_last_att = 3'(MAX_ATTEMPTS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACTIVE    = 3'd1,
        S_STOP_WAIT = 3'd2,
        S_PEND      = 3'd3,
        S_RECOV     = 3'd4,
        S_FAIL      = 3'd5
    } chan_state_t;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_LO    = 3'd2,
        R_HI    = 3'd3,
        R_STOP0 = 3'd4,
        R_STOP1 = 3'd5
    } seq_state_t;

    // ------------------------------------------------------------------
    // Reference tick detection (rising edge of each reference)
    // ------------------------------------------------------------------
    logic r_f_ref_d;
    logic r_f_ref_slow_d;
    logic w_tick;
    logic w_slow_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_f_ref_d      <= 1'b1;
            r_f_ref_slow_d <= 1'b1;
        end else begin
            r_f_ref_d      <= i_f_ref;
            r_f_ref_slow_d <= i_f_ref_slow;
        end
    end

    assign w_tick      = i_f_ref & ~r_f_ref_d;
    assign w_slow_tick = i_f_ref_slow & ~r_f_ref_slow_d;

    // ------------------------------------------------------------------
    // Shared recovery sequencer and round-robin arbiter
    // ------------------------------------------------------------------
    seq_state_t              r_seq;
    seq_state_t              w_seq_next;
    logic [WIDTH_T_LOW-1:0]  r_tlow;
    logic [3:0]              r_pulses;
    logic [2:0]              r_recov_ch;
    logic [2:0]              r_rr;
    logic [NUM_CH-1:0]       w_pend;
    logic                    w_grant_any;
    logic [2:0]              w_grant_idx;
    int                      w_best_dist;
    logic                    w_sel_sda;
    logic                    w_sel_scl;
    logic                    w_phase_end;
    logic                    w_pulse_inc;
    logic                    w_succ;
    logic                    w_fail_att;
    logic                    w_seq_sda;
    logic                    w_seq_scl;

    // Pick the pending channel with the smallest wrapped distance from r_rr.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_best_dist = NUM_CH;
        if (r_seq == R_IDLE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_pend[i] && (((i + NUM_CH - int'(r_rr)) % NUM_CH) < w_best_dist)) begin
                    w_best_dist = (i + NUM_CH - int'(r_rr)) % NUM_CH;
                    w_grant_idx = 3'(i);
                    w_grant_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_sda = 1'b1;
        w_sel_scl = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_recov_ch == 3'(i)) begin
                w_sel_sda = i_sda[i];
                w_sel_scl = i_scl[i];
            end
        end
    end

    always_comb begin
        w_seq_next  = r_seq;
        w_succ      = 1'b0;
        w_fail_att  = 1'b0;
        w_pulse_inc = 1'b0;
        w_seq_sda   = 1'b1;
        w_seq_scl   = 1'b1;
        w_phase_end = (r_tlow == '0);
        case (r_seq)
            R_IDLE: begin
                if (w_grant_any) w_seq_next = R_START;
            end
            R_START: begin
                w_seq_sda = 1'b0;
                if (w_phase_end) w_seq_next = R_LO;
            end
            R_LO: begin
                w_seq_scl = 1'b0;
                if (w_phase_end) w_seq_next = R_HI;
            end
            R_HI: begin
                if (w_phase_end) begin
                    if (w_sel_sda) begin
                        w_seq_next = R_STOP0;
                    end else if (r_pulses == c_pulses) begin
                        w_fail_att = 1'b1;
                        w_seq_next = R_IDLE;
                    end else begin
                        w_pulse_inc = 1'b1;
                        w_seq_next  = R_LO;
                    end
                end
            end
            R_STOP0: begin
                w_seq_sda = 1'b0;
                if (w_phase_end) w_seq_next = R_STOP1;
            end
            R_STOP1: begin
                if (w_phase_end) begin
                    w_succ     = w_sel_sda & w_sel_scl;
                    w_fail_att = ~(w_sel_sda & w_sel_scl);
                    w_seq_next = R_IDLE;
                end
            end
            default: w_seq_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seq      <= R_IDLE;
            r_tlow     <= c_t_low;
            r_pulses   <= '0;
            r_recov_ch <= '0;
            r_rr       <= '0;
        end else begin
            r_seq <= w_seq_next;
            // Every phase change restarts the phase timer.
            if (w_seq_next != r_seq) begin
                r_tlow <= c_t_low;
            end else if (w_tick && (r_tlow != '0)) begin
                r_tlow <= r_tlow - WIDTH_T_LOW'(1);
            end
            if (w_grant_any) begin
                r_recov_ch <= w_grant_idx;
                r_rr       <= 3'((int'(w_grant_idx) + 1) % NUM_CH);
                r_pulses   <= 4'd1;
            end else if (w_pulse_inc) begin
                r_pulses <= r_pulses + 4'd1;
            end
        end
    end

    assign o_recov_busy = (r_seq != R_IDLE);
    assign o_recov_ch   = r_recov_ch;

    // ------------------------------------------------------------------
    // Per-channel monitor
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        chan_state_t            r_state;
        chan_state_t            w_state_next;
        logic                   r_sda_d;
        logic                   r_scl_d;
        logic [WIDTH_STUCK-1:0] r_stuck_tmr;
        logic [WIDTH_T_HI-1:0]  r_thi;
        logic [WIDTH_T_LOW-1:0] r_qual;
        logic [2:0]             r_attempts;
        logic                   r_idle_to;
        logic                   w_edge;
        logic                   w_both_hi;
        logic                   w_start;
        logic                   w_stop;
        logic                   w_stuck_tc;
        logic                   w_granted;
        logic                   w_my_succ;
        logic                   w_my_fail;
        logic                   w_timeout;

        assign w_edge     = (i_sda[n] ^ r_sda_d) | (i_scl[n] ^ r_scl_d);
        assign w_both_hi  = i_sda[n] & i_scl[n];
        // START/STOP: SDA transition while SCL stays high.
        assign w_start    = r_scl_d & i_scl[n] & r_sda_d & ~i_sda[n];
        assign w_stop     = r_scl_d & i_scl[n] & ~r_sda_d & i_sda[n];
        assign w_stuck_tc = (r_stuck_tmr == '0);
        assign w_granted  = w_grant_any && (w_grant_idx == 3'(n));
        assign w_my_succ  = w_succ && (r_recov_ch == 3'(n));
        assign w_my_fail  = w_fail_att && (r_recov_ch == 3'(n));

        always_comb begin
            w_state_next = r_state;
            w_timeout    = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_stuck_tc)   w_state_next = S_PEND;
                    else if (w_start) w_state_next = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (w_stuck_tc) begin
                        w_state_next = S_PEND;
                    end else if (r_thi == '0) begin
                        w_state_next = S_IDLE;
                        w_timeout    = 1'b1;
                    end else if (w_stop) begin
                        w_state_next = S_STOP_WAIT;
                    end
                end
                S_STOP_WAIT: begin
                    if (w_stuck_tc)         w_state_next = S_PEND;
                    else if (!w_both_hi)    w_state_next = S_ACTIVE;
                    else if (r_qual == '0)  w_state_next = S_IDLE;
                end
                S_PEND: begin
                    if (w_granted) w_state_next = S_RECOV;
                end
                S_RECOV: begin
                    if (w_my_succ) begin
                        w_state_next = S_ACTIVE;
                    end else if (w_my_fail) begin
                        w_state_next = (r_attempts == c_last_att) ? S_FAIL : S_PEND;
                    end
                end
                S_FAIL: begin
                    if (i_clr_fail[n]) w_state_next = S_ACTIVE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_state     <= S_IDLE;
                r_sda_d     <= 1'b1;
                r_scl_d     <= 1'b1;
                r_stuck_tmr <= c_t_stk;
                r_thi       <= c_t_hi;
                r_qual      <= c_t_low;
                r_attempts  <= '0;
                r_idle_to   <= 1'b0;
            end else begin
                r_state   <= w_state_next;
                r_sda_d   <= i_sda[n];
                r_scl_d   <= i_scl[n];
                r_idle_to <= w_timeout;

                if (w_edge || w_both_hi) begin
                    r_stuck_tmr <= c_t_stk;
                end else if (w_slow_tick && (r_stuck_tmr != '0)) begin
                    r_stuck_tmr <= r_stuck_tmr - WIDTH_STUCK'(1);
                end

                if (!w_both_hi) begin
                    r_thi <= c_t_hi;
                end else if (w_tick && (r_thi != '0)) begin
                    r_thi <= r_thi - WIDTH_T_HI'(1);
                end

                // Qualify timer runs only while waiting after a STOP.
                if (r_state != S_STOP_WAIT) begin
                    r_qual <= c_t_low;
                end else if (w_tick && (r_qual != '0)) begin
                    r_qual <= r_qual - WIDTH_T_LOW'(1);
                end

                if (i_clr_fail[n]) begin
                    r_attempts <= '0;
                end else if ((r_state == S_RECOV) && w_my_succ) begin
                    r_attempts <= '0;
                end else if ((r_state == S_RECOV) && w_my_fail) begin
                    r_attempts <= r_attempts + 3'd1;
                end
            end
        end

        assign w_pend[n]         = (r_state == S_PEND);
        assign o_idle[n]         = (r_state == S_IDLE);
        assign o_idle_timeout[n] = r_idle_to;
        assign o_stuck[n]        = (r_state == S_PEND) | (r_state == S_RECOV) | (r_state == S_FAIL);
        assign o_fail[n]         = (r_state == S_FAIL);
        assign o_sda[n]          = (r_state == S_RECOV) ? w_seq_sda : 1'b1;
        assign o_scl[n]          = (r_state == S_RECOV) ? w_seq_scl : 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_passthru_idle_stuck_recover_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2c_passthru_idle_stuck_recover_mc
// Purpose  : Directed self-checking bench: idle via STOP, idle timeout,
//            stuck recovery (success and repeated failure), round-robin
//            grant order, and reset during recovery. Bus lines are modelled
//            as wired-AND of the external device and the DUT drive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_passthru_idle_stuck_recover_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       f_ref = 1'b0;
    logic       f_ref_slow = 1'b0;
    logic [1:0] ext_sda = 2'b11;
    logic [1:0] ext_scl = 2'b11;
    logic [1:0] clr_fail = 2'b00;
    logic [1:0] w_bus_sda;
    logic [1:0] w_bus_scl;
    logic [1:0] o_sda, o_scl, o_idle, o_idle_to, o_stuck, o_fail;
    logic       busy;
    logic [2:0] rch;

    int n_checks = 0;
    int n_errors = 0;

    assign w_bus_sda = ext_sda & o_sda;
    assign w_bus_scl = ext_scl & o_scl;

    i2c_passthru_idle_stuck_recover_mc #(
        .NUM_CH(2), .F_REF_T_LOW(4), .F_REF_T_HI(16), .F_REF_SLOW_T_STUCK_MAX(8),
        .RECOV_CLKS(9), .MAX_ATTEMPTS(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_f_ref(f_ref), .i_f_ref_slow(f_ref_slow),
        .i_sda(w_bus_sda), .i_scl(w_bus_scl), .i_clr_fail(clr_fail),
        .o_sda(o_sda), .o_scl(o_scl), .o_idle(o_idle), .o_idle_timeout(o_idle_to),
        .o_stuck(o_stuck), .o_fail(o_fail), .o_recov_busy(busy), .o_recov_ch(rch)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        f_ref      = ~f_ref;
        f_ref_slow = ~f_ref_slow;
    end

    // Reference tick model: a tick is a posedge that sees f_ref newly high.
    int   tick_cnt = 0;
    logic f_ref_prev = 1'b0;
    always @(posedge clk) begin
        if (f_ref && !f_ref_prev) tick_cnt <= tick_cnt + 1;
        f_ref_prev <= f_ref;
    end

    // Observers sampled on the falling edge.
    int         rise0 = 0, rise1 = 0, to_cnt0 = 0, to_cnt1 = 0, gcount = 0;
    logic [1:0] scl_prev = 2'b11;
    logic       busy_prev = 1'b0;
    logic [2:0] grant_log [0:31];
    always @(negedge clk) begin
        if (o_scl[0] && !scl_prev[0]) rise0++;
        if (o_scl[1] && !scl_prev[1]) rise1++;
        scl_prev = o_scl;
        if (o_idle_to[0]) to_cnt0++;
        if (o_idle_to[1]) to_cnt1++;
        if (busy && !busy_prev && gcount < 32) begin
            grant_log[gcount] = rch;
            gcount++;
        end
        busy_prev = busy;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0, prev, base0, base1, tb0, tb1, gbase;
        logic seen, stuck1_at_grant;

        // ---------------- reset state ----------------
        cyc(3);
        check_val("rst_sda", o_sda, 2'b11);
        check_val("rst_scl", o_scl, 2'b11);
        check_val("rst_idle", o_idle, 2'b11);
        check_val("rst_stuck_fail", {o_stuck, o_fail, o_idle_to}, 6'b0);
        check_val("rst_busy", busy, 1'b0);
        rst = 1'b0;
        cyc(4);

        // ---------------- ch0: START, data, STOP -> qualified idle ----------------
        ext_sda[0] = 1'b0; cyc(1);
        check_val("t1_active", o_idle[0], 1'b0);
        ext_scl[0] = 1'b0; cyc(2);
        ext_sda[0] = 1'b1; cyc(2);
        ext_scl[0] = 1'b1; cyc(2);
        ext_scl[0] = 1'b0; cyc(2);
        ext_sda[0] = 1'b0; cyc(2);
        ext_scl[0] = 1'b1; cyc(2);
        tb0 = to_cnt0;
        ext_sda[0] = 1'b1; cyc(1);
        c0 = tick_cnt; prev = c0; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            prev = tick_cnt;
            cyc(1);
            if (o_idle[0]) begin seen = 1'b1; break; end
        end
        check_val("t1_idle", seen, 1'b1);
        check_val("t1_qual_ticks", prev - c0, 4);
        check_val("t1_no_timeout", to_cnt0 - tb0, 0);

        // ---------------- ch1: START then both high -> timeout ----------------
        ext_sda[1] = 1'b0; cyc(1);
        check_val("t2_active", o_idle[1], 1'b0);
        ext_scl[1] = 1'b0; cyc(2);
        ext_sda[1] = 1'b1; cyc(2);
        tb1 = to_cnt1;
        c0 = tick_cnt;
        ext_scl[1] = 1'b1;
        prev = c0; seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            prev = tick_cnt;
            cyc(1);
            if (o_idle_to[1]) begin seen = 1'b1; break; end
        end
        check_val("t2_timeout_seen", seen, 1'b1);
        check_val("t2_thi_ticks", prev - c0, 16);
        check_val("t2_idle", o_idle[1], 1'b1);
        cyc(1);
        check_val("t2_pulse_end", o_idle_to[1], 1'b0);
        check_val("t2_pulse_count", to_cnt1 - tb1, 1);

        // ---------------- ch0 stuck, SDA frees during 3rd pulse ----------------
        ext_sda[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (busy) begin seen = 1'b1; break; end
        end
        check_val("t3_grant_wait", seen, 1'b1);
        check_val("t3_grant_ch", rch, 3'd0);
        check_val("t3_start_lines", {o_sda[0], o_scl[0], o_stuck[0]}, 3'b011);
        base0 = rise0; seen = 1'b0;
        for (int k = 0; k < 600; k++) begin
            cyc(1);
            if (rise0 - base0 >= 3) ext_sda[0] = 1'b1;
            if (!busy) begin seen = 1'b1; break; end
        end
        check_val("t3_done_wait", seen, 1'b1);
        check_val("t3_pulses", rise0 - base0, 3);
        check_val("t3_unstuck", o_stuck[0], 1'b0);
        check_val("t3_fail", o_fail[0], 1'b0);

        // ---------------- ch0 SDA low forever -> fail after 2 attempts ----------------
        ext_sda[0] = 1'b0;
        base0 = rise0; seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            cyc(1);
            if (o_fail[0]) begin seen = 1'b1; break; end
        end
        check_val("t4_fail_wait", seen, 1'b1);
        check_val("t4_pulses", rise0 - base0, 18);
        check_val("t4_stuck", o_stuck[0], 1'b1);
        check_val("t4_released", {o_sda[0], o_scl[0], busy}, 3'b110);
        ext_sda[0] = 1'b1; cyc(2);
        check_val("t4_sticky", o_fail[0], 1'b1);
        clr_fail[0] = 1'b1; cyc(1);
        clr_fail[0] = 1'b0;
        check_val("t4_clr_fail", {o_fail[0], o_stuck[0], o_idle[0]}, 3'b000);

        // ---------------- both channels stuck together ----------------
        rst = 1'b1; cyc(2);
        check_val("t5_rst_idle", {o_idle, busy}, 3'b110);
        rst = 1'b0; cyc(2);
        gbase = gcount; base0 = rise0; base1 = rise1;
        stuck1_at_grant = 1'b0;
        ext_sda = 2'b00;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            cyc(1);
            if (busy && (gcount - gbase == 1) && (rch == 3'd0)) stuck1_at_grant = o_stuck[1];
            if (rise0 - base0 >= 1) ext_sda[0] = 1'b1;
            if (rise1 - base1 >= 1) ext_sda[1] = 1'b1;
            if (!busy && (o_stuck == 2'b00) && (gcount - gbase >= 2)) begin seen = 1'b1; break; end
        end
        check_val("t5_done_wait", seen, 1'b1);
        check_val("t5_grants", gcount - gbase, 2);
        check_val("t5_first_ch", grant_log[gbase], 3'd0);
        check_val("t5_second_ch", grant_log[gbase + 1], 3'd1);
        check_val("t5_ch1_waiting", stuck1_at_grant, 1'b1);

        // ---------------- reset during R_LO ----------------
        ext_sda[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            cyc(1);
            if (busy && !o_scl[0]) begin seen = 1'b1; break; end
        end
        check_val("t6_rlo_wait", seen, 1'b1);
        rst = 1'b1; cyc(1);
        check_val("t6_lines", {o_sda, o_scl}, 4'b1111);
        check_val("t6_idle", o_idle, 2'b11);
        check_val("t6_busy", {busy, o_stuck}, 3'b000);
        rst = 1'b0;
        ext_sda[0] = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
